// File: rtl/softmax_argmax.sv
// Streaming top-2 reader: tracks best/runner-up probability over one frame, holds result until accepted.
// Optional frame-length checking is built only when ARGMAX_LENGTH_CHECK_EN is defined.
module softmax_argmax #(
  parameter int NUM_CLASSES = 1024,
  parameter int DATA_W      = 16,
  parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_index,
  output logic [DATA_W-1:0] out_prob,
  output logic [IDX_W-1:0]  out_second_index,
  output logic [DATA_W-1:0] out_margin,
  output logic [IDX_W:0]    out_count,
  output logic              out_len_err
);

  // state | meaning
  // ACCUM | accepting beats of the current frame
  // HOLD  | result presented, waiting for out_ready
  typedef enum logic {ACCUM, HOLD} state_t;

  state_t            state, state_nxt;
  logic [IDX_W:0]    pos;
  logic [DATA_W-1:0] best_val, sec_val, nb_val, ns_val;
  logic [IDX_W-1:0]  best_idx, sec_idx, nb_idx, ns_idx;
  logic [IDX_W-1:0]  cur_idx;
  logic              accept, last_slot, frame_end, release_out;

  assign in_ready    = (state == ACCUM) && !rst;
  assign out_valid   = (state == HOLD);
  assign accept      = in_valid && in_ready;
  assign cur_idx     = pos[IDX_W-1:0];
  assign last_slot   = (pos == (IDX_W+1)'(NUM_CLASSES - 1));
  assign frame_end   = accept && (in_last || last_slot);
  assign release_out = (state == HOLD) && out_ready;

  // Strict compares so that equal values never displace an earlier index.
  always_comb begin
    nb_val = best_val;
    nb_idx = best_idx;
    ns_val = sec_val;
    ns_idx = sec_idx;
    if (pos == '0) begin
      nb_val = in_data;
      nb_idx = cur_idx;
      ns_val = '0;
      ns_idx = '0;
    end else if (in_data > best_val) begin
      ns_val = best_val;
      ns_idx = best_idx;
      nb_val = in_data;
      nb_idx = cur_idx;
    end else if (in_data > sec_val) begin
      ns_val = in_data;
      ns_idx = cur_idx;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (frame_end) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ACCUM;
      pos              <= '0;
      best_val         <= '0;
      best_idx         <= '0;
      sec_val          <= '0;
      sec_idx          <= '0;
      out_index        <= '0;
      out_prob         <= '0;
      out_second_index <= '0;
      out_margin       <= '0;
      out_count        <= '0;
    end else begin
      state <= state_nxt;
      if (frame_end || release_out) begin
        pos      <= '0;
        best_val <= '0;
        best_idx <= '0;
        sec_val  <= '0;
        sec_idx  <= '0;
      end else if (accept) begin
        pos      <= pos + (IDX_W+1)'(1);
        best_val <= nb_val;
        best_idx <= nb_idx;
        sec_val  <= ns_val;
        sec_idx  <= ns_idx;
      end
      if (frame_end) begin
        out_index        <= nb_idx;
        out_prob         <= nb_val;
        out_second_index <= ns_idx;
        out_margin       <= nb_val - ns_val;
        out_count        <= pos + (IDX_W+1)'(1);
      end
    end
  end

`ifdef ARGMAX_LENGTH_CHECK_EN
  // A frame ending on the last slot without in_last is also a length error.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_len_err <= 1'b0;
    end else if (frame_end) begin
      out_len_err <= in_last ? !last_slot : 1'b1;
    end
  end
`else
  assign out_len_err = 1'b0;
`endif

endmodule

// File: tb/tb_softmax_argmax.sv
// Self-checking bench for softmax_argmax: directed and randomized frames against a scan-based top-2 model.
module tb_softmax_argmax;
  localparam int N  = 1024;
  localparam int DW = 16;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst, in_valid, in_last, out_ready;
  logic          in_ready, out_valid, out_len_err;
  logic [DW-1:0] in_data, out_prob, out_margin;
  logic [IW-1:0] out_index, out_second_index;
  logic [IW:0]   out_count;

  int vectors = 0;
  int miscompares = 0;
  int frame [0:N-1];
  int e_idx, e_prob, e_sec, e_margin, e_count, e_err;

  always #5 clk = ~clk;

  softmax_argmax dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_prob(out_prob), .out_second_index(out_second_index),
    .out_margin(out_margin), .out_count(out_count), .out_len_err(out_len_err)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: top-1 is the lowest-index maximum, top-2 the lowest-index maximum of the rest.
  task automatic model(input int n, input bit by_last);
    int b, s, sv;
    b = 0;
    s = -1;
    for (int i = 1; i < n; i++) if (frame[i] > frame[b]) b = i;
    for (int i = 0; i < n; i++)
      if (i != b && (s < 0 || frame[i] > frame[s])) s = i;
    sv       = (s < 0) ? 0 : frame[s];
    e_idx    = b;
    e_prob   = frame[b];
    e_sec    = (s < 0) ? 0 : s;
    e_margin = frame[b] - sv;
    e_count  = n;
`ifdef ARGMAX_LENGTH_CHECK_EN
    e_err = by_last ? int'(n != N) : 1;
`else
    e_err = 0;
`endif
  endtask

  task automatic send_beats(input int n, input bit last_on_final);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(frame[i]);
      in_last  = last_on_final && (i == n - 1);
      @(negedge clk);
      chk("in_ready_beat", 32'(in_ready), 1);
      chk("out_valid_beat", 32'(out_valid), 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic check_result;
    chk("out_valid", 32'(out_valid), 1);
    chk("in_ready_hold", 32'(in_ready), 0);
    chk("out_index", 32'(out_index), e_idx);
    chk("out_prob", 32'(out_prob), e_prob);
    chk("out_second_index", 32'(out_second_index), e_sec);
    chk("out_margin", 32'(out_margin), e_margin);
    chk("out_count", 32'(out_count), e_count);
    chk("out_len_err", 32'(out_len_err), e_err);
  endtask

  task automatic handshake;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_frame(input int n, input bit by_last);
    send_beats(n, by_last);
    model(n, by_last);
    @(negedge clk);
    check_result();
    handshake();
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_index", 32'(out_index), 0);
    chk("rst_out_prob", 32'(out_prob), 0);
    chk("rst_out_margin", 32'(out_margin), 0);
    chk("rst_out_count", 32'(out_count), 0);
    chk("rst_out_len_err", 32'(out_len_err), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", 32'(in_ready), 1);
    @(posedge clk); #1;

    // Full ramp frame with last on the final slot
    for (int i = 0; i < N; i++) frame[i] = i;
    run_frame(N, 1'b1);

    // Short frame
    frame[0] = 'h1000; frame[1] = 'h8000; frame[2] = 'h2000;
    run_frame(3, 1'b1);

    // Single-beat frame: margin equals the value itself
    frame[0] = 'h1234;
    run_frame(1, 1'b1);

    // Ties frame, then backpressure with junk offered during HOLD
    frame[0] = 5; frame[1] = 9; frame[2] = 9; frame[3] = 2;
    frame[4] = 9; frame[5] = 1; frame[6] = 0; frame[7] = 3;
    send_beats(8, 1'b1);
    model(8, 1'b1);
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check_result();
    end
    handshake();
    n = 6;
    for (int i = 0; i < n; i++) frame[i] = $urandom_range(1, 16'hFFFE);
    send_beats(n, 1'b1);
    model(n, 1'b1);
    @(negedge clk);
    check_result();
    handshake();

    // Missing last: frame terminates on the final slot
    for (int i = 0; i < N; i++) frame[i] = $urandom_range(1, 16'hFFFF);
    run_frame(N, 1'b0);

    // Randomized frames, odd ones with a tiny value range to force ties
    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++)
        frame[i] = (k % 2 == 1) ? $urandom_range(1, 3) : $urandom_range(1, 16'hFFFF);
      run_frame(n, 1'b1);
    end

    // Reset mid-frame discards partial beats
    for (int i = 0; i < 4; i++) frame[i] = 16'hFFFF;
    send_beats(4, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready), 0);
    chk("midrst_out_valid", 32'(out_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid_after", 32'(out_valid), 0);
    chk("midrst_in_ready_after", 32'(in_ready), 1);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) frame[i] = $urandom_range(1, 16'hFFFE);
    run_frame(5, 1'b1);

    @(negedge clk);
    chk("final_out_valid", 32'(out_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
